// File: rtl/updown_counter_param_if.sv
// Counter control/status bundle: count controls, load value, count and flags.
// The master drives en/load/up/d; the counter (slave) returns q/tc/ovf.
interface updown_counter_param_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic             up;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (output en, load, up, d, input q, tc, ovf);
  modport slave  (input en, load, up, d, output q, tc, ovf);
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with clamped parallel load, count enable,
// programmable modulus (MAX+1), combinational terminal count and a
// registered limit-step pulse.
// Build option: define UPDOWN_COUNTER_SAT_EN to saturate at the limits
// instead of wrapping modulo MAX+1.
module updown_counter_param #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst,
  updown_counter_param_if.slave  bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_zero, limit;

  assign at_max  = (q_q == MAX);
  assign at_zero = (q_q == '0);
  // Next enabled step crosses a limit; a load suppresses it, reset does not.
  assign limit   = bus.en & ~bus.load & ((bus.up & at_max) | (~bus.up & at_zero));

  assign bus.q   = q_q;
  assign bus.tc  = limit;
  assign bus.ovf = ovf_q;

  // Next-state: load (clamped to MAX) beats count, count beats hold.
  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    if (bus.load) begin
      q_d = (bus.d > MAX) ? MAX : bus.d;
    end else if (bus.en) begin
      ovf_d = limit;
      if (limit) begin
`ifdef UPDOWN_COUNTER_SAT_EN
        q_d = q_q;
`else
        q_d = bus.up ? '0 : MAX;
`endif
      end else begin
        q_d = bus.up ? q_q + 1'b1 : q_q - 1'b1;
      end
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

endmodule
